// File: rtl/ser_rx_deframer_if.sv
// Parallel-side bundle of the serial deframer: recovered word, status strobes and busy.
`timescale 1ns/1ps
interface ser_rx_deframer_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              frame_err;
  logic              parity_err;
  logic              busy;

  modport master (output dout, dout_valid, frame_err, parity_err, busy);
  modport slave  (input  dout, dout_valid, frame_err, parity_err, busy);
endinterface

// File: rtl/ser_rx_deframer.sv
// Serial frame receiver: start bit, DATA_W data bits LSB first, optional even parity, stop bit.
// Define PARITY_EN to build the parity bit check; otherwise parity_err is constant 0.
`timescale 1ns/1ps
module ser_rx_deframer #(
  parameter int DATA_W  = 8,
  parameter int BIT_CYC = 4
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              sin,
  ser_rx_deframer_if.master bus
);
  localparam int CNT_W  = $clog2(BIT_CYC);
  localparam int BITN_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(BIT_CYC - 1);
  localparam logic [CNT_W-1:0]  CNT_MID   = CNT_W'(BIT_CYC / 2);
  localparam logic [BITN_W-1:0] BITN_LAST = BITN_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
`ifdef PARITY_EN
    , S_PARITY = 3'd5
`endif
  } state_t;

  state_t              r_state;
  state_t              w_state_next;
  logic [1:0]          r_sync;
  logic                w_s;
  logic [CNT_W-1:0]    r_cnt;
  logic [BITN_W-1:0]   r_bitn;
  logic [DATA_W-1:0]   r_shreg;
  logic [DATA_W-1:0]   w_shreg_next;
  logic                w_sample;
  logic                w_par_bad;
  logic [DATA_W-1:0]   r_dout;
  logic                r_valid;
  logic                r_ferr;
  logic                w_valid_next;
  logic                w_ferr_next;
`ifdef PARITY_EN
  logic                r_par;
  logic                r_perr;
  logic                w_perr_next;
  assign w_par_bad = ^{r_shreg, r_par};
`else
  assign w_par_bad = 1'b0;
`endif

  // Two-flop synchronizer; resets to the idle line level so no false start after reset.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_sync <= 2'b11;
    else         r_sync <= {r_sync[0], sin};
  end
  assign w_s      = r_sync[1];
  assign w_sample = (r_cnt == CNT_LAST);

  generate
    if (DATA_W > 1) begin : g_shift
      assign w_shreg_next = {w_s, r_shreg[DATA_W-1:1]};
    end else begin : g_shift_one
      assign w_shreg_next = w_s;
    end
  endgenerate

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) r_state <= S_IDLE;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (!w_s) w_state_next = S_START;
      S_START: if (w_sample) w_state_next = w_s ? S_IDLE : S_DATA;
      S_DATA:  if (w_sample && (r_bitn == BITN_LAST))
`ifdef PARITY_EN
                 w_state_next = S_PARITY;
      S_PARITY: if (w_sample) w_state_next = S_STOP;
`else
                 w_state_next = S_STOP;
`endif
      S_STOP:  if (w_sample) w_state_next = w_s ? S_IDLE : S_BREAK;
      S_BREAK: if (w_s) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Strobes are decided at the stop sample and registered, so they appear one cycle later.
  always_comb begin
    w_valid_next = 1'b0;
    w_ferr_next  = 1'b0;
`ifdef PARITY_EN
    w_perr_next  = 1'b0;
`endif
    if ((r_state == S_STOP) && w_sample) begin
      w_valid_next = w_s & ~w_par_bad;
      w_ferr_next  = ~w_s;
`ifdef PARITY_EN
      w_perr_next  = w_par_bad;
`endif
    end
  end

  // Idle preloads the half-bit offset so every later sample falls at bit centre.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_cnt   <= '0;
      r_bitn  <= '0;
      r_shreg <= '0;
`ifdef PARITY_EN
      r_par   <= 1'b0;
`endif
    end else begin
      if (r_state == S_IDLE) r_cnt <= CNT_MID;
      else if (w_sample)     r_cnt <= '0;
      else                   r_cnt <= r_cnt + CNT_W'(1);
      if (w_sample) begin
        case (r_state)
          S_START: r_bitn <= '0;
          S_DATA: begin
            r_shreg <= w_shreg_next;
            if (r_bitn != BITN_LAST) r_bitn <= r_bitn + BITN_W'(1);
          end
`ifdef PARITY_EN
          S_PARITY: r_par <= w_s;
`endif
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef PARITY_EN
      r_perr  <= 1'b0;
`endif
    end else begin
      r_valid <= w_valid_next;
      r_ferr  <= w_ferr_next;
`ifdef PARITY_EN
      r_perr  <= w_perr_next;
`endif
      if (w_valid_next) r_dout <= r_shreg;
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.frame_err  = r_ferr;
`ifdef PARITY_EN
  assign bus.parity_err = r_perr;
`else
  assign bus.parity_err = 1'b0;
`endif
  assign bus.busy       = (r_state != S_IDLE);
endmodule

// File: tb/tb_ser_rx_deframer.sv
// Directed and randomized frame stimulus for ser_rx_deframer, checked against a frame-level model.
`timescale 1ns/1ps
module tb_ser_rx_deframer;
  localparam int DATA_W  = 8;
  localparam int BIT_CYC = 4;
`ifdef PARITY_EN
  localparam int FRAME_BITS = DATA_W + 3;
`else
  localparam int FRAME_BITS = DATA_W + 2;
`endif
  localparam int LAT = 2 + (FRAME_BITS * BIT_CYC - 2) + 1;

  logic clk = 1'b0;
  logic nreset = 1'b0;
  logic sin = 1'b1;

  ser_rx_deframer_if #(.DATA_W(DATA_W)) bus ();
  ser_rx_deframer #(.DATA_W(DATA_W), .BIT_CYC(BIT_CYC)) dut (
    .clk(clk), .nreset(nreset), .sin(sin), .bus(bus)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  // Observation side: records every strobe, its cycle, and any protocol violation.
  int n_valid = 0, n_ferr = 0, n_perr = 0, n_overlap = 0, n_wide = 0, n_stray = 0, busy_hi = 0;
  logic [DATA_W-1:0] got_q[$];
  int unsigned       vcyc_q[$];
  logic              prev_valid = 1'b0, prev_ferr = 1'b0;
  logic [DATA_W-1:0] prev_dout = '0;

  always @(negedge clk) begin
    if (bus.dout_valid) begin
      n_valid++;
      got_q.push_back(bus.dout);
      vcyc_q.push_back(cyc);
    end
    if (bus.frame_err)  n_ferr++;
    if (bus.parity_err) n_perr++;
    if (bus.dout_valid && bus.frame_err) n_overlap++;
    if ((bus.dout_valid && prev_valid) || (bus.frame_err && prev_ferr)) n_wide++;
    if (nreset && !bus.dout_valid && (bus.dout !== prev_dout)) n_stray++;
    if (bus.busy) busy_hi++;
    prev_valid = bus.dout_valid;
    prev_ferr  = bus.frame_err;
    prev_dout  = bus.dout;
  end

  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  int unsigned start_cyc;

  task automatic send_bit(logic b);
    sin = b;
    tick(BIT_CYC);
  endtask

  task automatic send_frame(logic [DATA_W-1:0] d, logic stop);
    start_cyc = cyc;
    send_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
`ifdef PARITY_EN
    send_bit(^d);
`endif
    send_bit(stop);
  endtask

`ifdef PARITY_EN
  task automatic send_frame_badpar(logic [DATA_W-1:0] d);
    send_bit(1'b0);
    for (int i = 0; i < DATA_W; i++) send_bit(d[i]);
    send_bit(~(^d));
    send_bit(1'b1);
  endtask
`endif

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_dout;
  logic [DATA_W-1:0] d;
  logic              bad;
  int                v0, f0, p0, b0, exp_ferr;

  initial begin
    // 1: reset held in idle
    tick(3);
    check("rst_dout", bus.dout, 0);
    check("rst_valid", bus.dout_valid, 0);
    check("rst_ferr", bus.frame_err, 0);
    check("rst_perr", bus.parity_err, 0);
    check("rst_busy", bus.busy, 0);
    nreset = 1'b1;
    tick(4);
    exp_dout = '0;

    // 2: single good frame, latency window
    got_q.delete(); vcyc_q.delete();
    v0 = n_valid; f0 = n_ferr; p0 = n_perr;
    send_frame(8'hA5, 1'b1);
    tick(4);
    exp_dout = 8'hA5;
    check("a5_count", n_valid - v0, 1);
    check("a5_data", (got_q.size() > 0) ? got_q[0] : 'x, 8'hA5);
    check("a5_lat", (vcyc_q.size() > 0) &&
                    (vcyc_q[0] - start_cyc >= LAT - 1) && (vcyc_q[0] - start_cyc <= LAT + 1), 1);
    check("a5_noerr", (n_ferr - f0) + (n_perr - p0), 0);
    check("a5_dout", bus.dout, exp_dout);

    // 3: back-to-back frames, zero gap
    got_q.delete(); vcyc_q.delete();
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(4);
    exp_dout = 8'hFF;
    check("b2b_count", got_q.size(), 2);
    check("b2b_first", (got_q.size() > 1) ? got_q[0] : 'x, 8'h00);
    check("b2b_second", (got_q.size() > 1) ? got_q[1] : 'x, 8'hFF);
    check("b2b_spacing", (vcyc_q.size() > 1) ? vcyc_q[1] - vcyc_q[0] : 0, FRAME_BITS * BIT_CYC);

    // 4: one-clock glitch
    v0 = n_valid; f0 = n_ferr; b0 = busy_hi;
    sin = 1'b0; tick(1); sin = 1'b1;
    tick(10);
    check("glitch_busy_seen", (busy_hi - b0) > 0, 1);
    check("glitch_idle", bus.busy, 0);
    check("glitch_nostrobe", (n_valid - v0) + (n_ferr - f0), 0);
    check("glitch_dout", bus.dout, exp_dout);

    // 5: frame error and break, then recovery
    send_frame(8'hA5, 1'b1);
    tick(2);
    exp_dout = 8'hA5;
    v0 = n_valid; f0 = n_ferr;
    send_frame(8'h3C, 1'b0);
    tick(BIT_CYC * 4);
    check("ferr_count", n_ferr - f0, 1);
    check("ferr_novalid", n_valid - v0, 0);
    check("ferr_dout", bus.dout, exp_dout);
    check("break_busy", bus.busy, 1);
    sin = 1'b1;
    tick(6);
    check("break_exit", bus.busy, 0);
    send_frame(8'h11, 1'b1);
    tick(4);
    exp_dout = 8'h11;
    check("recover_dout", bus.dout, exp_dout);

    // 6: reset during data bit 4
    sin = 1'b0; tick(BIT_CYC);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    sin = 1'b1; tick(BIT_CYC / 2);
    nreset = 1'b0;
    #1;
    check("midrst_dout", bus.dout, 0);
    check("midrst_busy", bus.busy, 0);
    check("midrst_strobes", {bus.dout_valid, bus.frame_err, bus.parity_err}, 0);
    tick(3);
    nreset = 1'b1;
    tick(6);
    exp_dout = '0;
    send_frame(8'h5A, 1'b1);
    tick(4);
    exp_dout = 8'h5A;
    check("postrst_dout", bus.dout, exp_dout);

    // Randomized frames with random gaps and occasional bad stop bits
    got_q.delete(); vcyc_q.delete(); exp_q.delete();
    f0 = n_ferr; exp_ferr = 0;
    for (int i = 0; i < 14; i++) begin
      d   = DATA_W'($urandom);
      bad = ($urandom_range(0, 3) == 0);
      send_frame(d, ~bad);
      if (bad) begin
        exp_ferr++;
        tick(BIT_CYC * $urandom_range(1, 4));
        sin = 1'b1;
        tick(BIT_CYC * 2);
      end else begin
        exp_q.push_back(d);
        exp_dout = d;
        tick(BIT_CYC * $urandom_range(0, 2));
      end
    end
    sin = 1'b1;
    tick(12);
    check("rand_count", got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      check($sformatf("rand_word%0d", i), (i < got_q.size()) ? got_q[i] : 'x, exp_q[i]);
    check("rand_ferr", n_ferr - f0, exp_ferr);
    check("rand_dout", bus.dout, exp_dout);

`ifdef PARITY_EN
    v0 = n_valid; p0 = n_perr;
    send_frame_badpar(8'h01);
    tick(4);
    check("par_err", n_perr - p0, 1);
    check("par_novalid", n_valid - v0, 0);
    check("par_dout", bus.dout, exp_dout);
`else
    check("par_tied", n_perr, 0);
`endif

    check("overlap", n_overlap, 0);
    check("pulse_width", n_wide, 0);
    check("stray_write", n_stray, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
